// File: rtl/dpll_sequencer_if.sv
// Handshake bundle between the DPLL sequencer, its host and the decision and
// propagation units. master = sequencer side, slave = host/sub-unit side.
interface dpll_sequencer_if #(
    parameter int MAX_DEPTH = 16,
    parameter int CLAUSE_AW = 2,
    parameter int LEN_W     = 3,
    parameter int PAY_W     = 8,
    parameter int NUM_W     = 4
);
    localparam int NUM_CLAUSES = 2 ** CLAUSE_AW;
    localparam int CLAUSE_W    = LEN_W + PAY_W;
    localparam int LIT_W       = NUM_W + 1;
    localparam int DEPTH_W     = $clog2(MAX_DEPTH + 1);

    logic                                   start;
    logic [NUM_CLAUSES-1:0][CLAUSE_W-1:0]   formula_in;
    logic                                   busy;
    logic                                   done;
    logic                                   sat;
    logic                                   unsat;
    logic                                   err;
    logic [DEPTH_W-1:0]                     depth;
    logic                                   dec_find;
    logic [NUM_CLAUSES-1:0][CLAUSE_W-1:0]   dec_formula;
    logic                                   dec_ended;
    logic [LIT_W-1:0]                       dec_lit;
    logic                                   prop_start;
    logic [NUM_CLAUSES-1:0][CLAUSE_W-1:0]   prop_formula;
    logic [LIT_W-1:0]                       prop_lit;
    logic                                   prop_done;
    logic                                   prop_conflict;
    logic [NUM_CLAUSES-1:0][CLAUSE_W-1:0]   prop_result;

    modport master (
        input  start, formula_in, dec_ended, dec_lit, prop_done, prop_conflict, prop_result,
        output busy, done, sat, unsat, err, depth, dec_find, dec_formula,
               prop_start, prop_formula, prop_lit
    );

    modport slave (
        output start, formula_in, dec_ended, dec_lit, prop_done, prop_conflict, prop_result,
        input  busy, done, sat, unsat, err, depth, dec_find, dec_formula,
               prop_start, prop_formula, prop_lit
    );
endinterface

// File: rtl/dpll_sequencer.sv
// DPLL control FSM: alternates decide/propagate, keeps the decision stack of
// formula snapshots and performs chronological backtracking with polarity flip.
module dpll_sequencer #(
    parameter int MAX_DEPTH  = 16,
    parameter int WAIT_LIMIT = 4096,
    parameter int CLAUSE_AW  = 2,
    parameter int LEN_W      = 3,
    parameter int PAY_W      = 8,
    parameter int NUM_W      = 4
) (
    input logic              clock,
    input logic              reset,
    dpll_sequencer_if.master bus
);
    localparam int NUM_CLAUSES = 2 ** CLAUSE_AW;
    localparam int CLAUSE_W    = LEN_W + PAY_W;
    localparam int LIT_W       = NUM_W + 1;
    localparam int DEPTH_W     = $clog2(MAX_DEPTH + 1);
    localparam int IDX_W       = $clog2(MAX_DEPTH);
    localparam int WD_W        = $clog2(WAIT_LIMIT + 1);

    typedef logic [NUM_CLAUSES-1:0][CLAUSE_W-1:0] formula_t;
    typedef logic [LIT_W-1:0] lit_t;
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_DEC_REQ, S_DEC_WAIT, S_PROP_REQ, S_PROP_WAIT, S_BACKTRACK, S_FINISH
    } state_t;

    state_t             state_q, state_d;
    formula_t           cur_formula_q, cur_formula_d;
    lit_t               cur_lit_q, cur_lit_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               sat_q, sat_d, unsat_q, unsat_d, err_q, err_d;
    logic               dec_find_q, dec_find_d, prop_start_q, prop_start_d;
    formula_t           snap_q [MAX_DEPTH];
    formula_t           snap_d [MAX_DEPTH];
    lit_t               slit_q [MAX_DEPTH];
    lit_t               slit_d [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] flip_q, flip_d;

    logic               empty;
    logic [IDX_W-1:0]   push_idx, top_idx;

    always_comb begin
        empty = 1'b1;
        for (int c = 0; c < NUM_CLAUSES; c++)
            if (cur_formula_q[c][CLAUSE_W-1 -: LEN_W] != '0) empty = 1'b0;
    end

    assign push_idx = depth_q[IDX_W-1:0];
    assign top_idx  = IDX_W'(depth_q - 1'b1);

    always_comb begin
        state_d       = state_q;
        cur_formula_d = cur_formula_q;
        cur_lit_d     = cur_lit_q;
        depth_d       = depth_q;
        wd_d          = wd_q;
        busy_d        = busy_q;
        sat_d         = sat_q;
        unsat_d       = unsat_q;
        err_d         = err_q;
        done_d        = 1'b0;
        dec_find_d    = 1'b0;
        prop_start_d  = 1'b0;
        snap_d        = snap_q;
        slit_d        = slit_q;
        flip_d        = flip_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                cur_formula_d = bus.formula_in;
                sat_d   = 1'b0;
                unsat_d = 1'b0;
                err_d   = 1'b0;
                depth_d = '0;
                busy_d  = 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (empty) begin
                    sat_d   = 1'b1;
                    state_d = S_FINISH;
                end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    dec_find_d = 1'b1;
                    state_d    = S_DEC_REQ;
                end
            end
            S_DEC_REQ: begin
                wd_d    = '0;
                state_d = S_DEC_WAIT;
            end
            // Watchdog: WAIT_LIMIT cycles in a wait state without an answer is fatal.
            S_DEC_WAIT: begin
                if (bus.dec_ended) begin
                    snap_d[push_idx] = cur_formula_q;
                    slit_d[push_idx] = bus.dec_lit;
                    flip_d[push_idx] = 1'b0;
                    depth_d      = depth_q + 1'b1;
                    cur_lit_d    = bus.dec_lit;
                    prop_start_d = 1'b1;
                    state_d      = S_PROP_REQ;
                end else if (wd_q == WD_W'(WAIT_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_PROP_REQ: begin
                wd_d    = '0;
                state_d = S_PROP_WAIT;
            end
            S_PROP_WAIT: begin
                if (bus.prop_done) begin
                    if (bus.prop_conflict) begin
                        state_d = S_BACKTRACK;
                    end else begin
                        cur_formula_d = bus.prop_result;
                        state_d       = S_CHECK;
                    end
                end else if (wd_q == WD_W'(WAIT_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            // One stack action per cycle: flip an untried top, else pop it.
            S_BACKTRACK: begin
                if (depth_q == '0) begin
                    unsat_d = 1'b1;
                    state_d = S_FINISH;
                end else if (!flip_q[top_idx]) begin
                    flip_d[top_idx] = 1'b1;
                    cur_lit_d       = {slit_q[top_idx][LIT_W-1:1], ~slit_q[top_idx][0]};
                    cur_formula_d   = snap_q[top_idx];
                    prop_start_d    = 1'b1;
                    state_d         = S_PROP_REQ;
                end else begin
                    depth_d = depth_q - 1'b1;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cur_formula_q <= '0;
            cur_lit_q     <= '0;
            depth_q       <= '0;
            wd_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sat_q         <= 1'b0;
            unsat_q       <= 1'b0;
            err_q         <= 1'b0;
            dec_find_q    <= 1'b0;
            prop_start_q  <= 1'b0;
            flip_q        <= '0;
            for (int i = 0; i < MAX_DEPTH; i++) begin
                snap_q[i] <= '0;
                slit_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cur_formula_q <= cur_formula_d;
            cur_lit_q     <= cur_lit_d;
            depth_q       <= depth_d;
            wd_q          <= wd_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            sat_q         <= sat_d;
            unsat_q       <= unsat_d;
            err_q         <= err_d;
            dec_find_q    <= dec_find_d;
            prop_start_q  <= prop_start_d;
            flip_q        <= flip_d;
            snap_q        <= snap_d;
            slit_q        <= slit_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.sat          = sat_q;
    assign bus.unsat        = unsat_q;
    assign bus.err          = err_q;
    assign bus.depth        = depth_q;
    assign bus.dec_find     = dec_find_q;
    assign bus.dec_formula  = cur_formula_q;
    assign bus.prop_start   = prop_start_q;
    assign bus.prop_formula = cur_formula_q;
    assign bus.prop_lit     = cur_lit_q;
endmodule

// File: tb/tb_dpll_sequencer.sv
// Randomized bench for dpll_sequencer: stub sub-units driven by deterministic
// oracles, and an iterative DPLL search model that predicts requests and results.
module tb_dpll_sequencer;
    localparam int MAXD = 2, WL = 8, CAW = 2, LENW = 3, PAYW = 8, NUMW = 4;
    localparam int NC = 4, CW = LENW + PAYW, FW = NC * CW, LW = NUMW + 1;
    localparam int M_RAND = 0, M_EMPTY = 1, M_CONF_ONCE = 2, M_CONFLICT = 3, M_STUCK = 4;

    typedef logic [NC-1:0][CW-1:0] fvec;
    typedef logic [LW-1:0] lvec;
    typedef struct packed { logic kind; fvec f; lvec l; } ev_t; // kind 0 = decide, 1 = propagate

    logic clock = 1'b0, reset = 1'b1;
    always #5 clock = ~clock;

    dpll_sequencer_if #(.MAX_DEPTH(MAXD), .CLAUSE_AW(CAW), .LEN_W(LENW), .PAY_W(PAYW), .NUM_W(NUMW)) bus ();
    dpll_sequencer #(.MAX_DEPTH(MAXD), .WAIT_LIMIT(WL), .CLAUSE_AW(CAW), .LEN_W(LENW),
                     .PAY_W(PAYW), .NUM_W(NUMW)) dut (.clock(clock), .reset(reset), .bus(bus));

    int checks = 0, errors = 0;
    int mode = M_EMPTY, dec_cnt = 0;
    int unsigned seed = 1;
    bit dec_hang = 0, prop_hang = 0, active = 0;
    ev_t exp_q[$];
    fvec seen_pf[$];
    lvec seen_pl[$];
    logic [2:0] exp_res;   // {sat, unsat, err}
    int exp_depth;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic int unsigned hsh(input fvec f, input lvec l);
        logic [FW-1:0] fl = f;
        int unsigned h = seed ^ 32'h811c9dc5;
        for (int i = 0; i < FW; i++) h = (h ^ {31'd0, fl[i]}) * 32'h01000193;
        for (int i = 0; i < LW; i++) h = (h ^ {31'd0, l[i]}) * 32'h01000193;
        return h;
    endfunction

    function automatic bit is_empty(input fvec f);
        for (int c = 0; c < NC; c++) if (f[c][CW-1:PAYW] != '0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic lvec dec_fn(input fvec f);
        int unsigned h = hsh(f, '0);
        if (mode == M_RAND) return {h[7:4], h[0]};
        return {4'd3, 1'b1};
    endfunction

    function automatic void prop_fn(input fvec f, input lvec l, output logic c, output fvec r);
        int unsigned h = hsh(f, l), x;
        c = 1'b0;
        r = '0;
        case (mode)
            M_CONF_ONCE: c = l[0];
            M_CONFLICT:  c = 1'b1;
            M_STUCK:     r = f;
            M_RAND: begin
                c = (h[1:0] == 2'd0);
                for (int k = 0; k < NC; k++) begin
                    x = (h ^ (k * 32'h9e3779b9)) * 32'h2545f491 + 32'd12345;
                    r[k] = {(h[4:2] < 3'd3) ? 3'b000 : x[2:0], x[15:8]};
                end
                if (h[4:2] >= 3'd3) r[0][PAYW] = 1'b1;
            end
            default: ;
        endcase
    endfunction

    // Chronological DPLL search over the oracles: each level tries the decided
    // polarity, then its complement, before giving up to the level above.
    function automatic void model(input fvec f0);
        fvec mf[MAXD];
        lvec ml[MAXD];
        int  mp[MAXD];
        fvec f = f0, r;
        logic c;
        lvec pl;
        int d = 0, k = 0;
        bit desc = 1, fin = 0;
        exp_q.delete();
        while (!fin) begin
            if (desc) begin
                if (is_empty(f)) begin exp_res = 3'b100; exp_depth = d; fin = 1; end
                else if (d == MAXD) begin exp_res = 3'b001; exp_depth = d; fin = 1; end
                else begin
                    exp_q.push_back('{1'b0, f, '0});
                    mf[d] = f; ml[d] = dec_fn(f); mp[d] = 0; k = d; desc = 0;
                end
            end else begin
                pl = {ml[k][LW-1:1], ml[k][0] ^ mp[k][0]};
                exp_q.push_back('{1'b1, mf[k], pl});
                prop_fn(mf[k], pl, c, r);
                if (!c) begin f = r; d = k + 1; desc = 1; end
                else begin
                    mp[k]++;
                    while (!fin && mp[k] == 2) begin
                        if (k == 0) begin exp_res = 3'b010; exp_depth = 0; fin = 1; end
                        else begin k--; mp[k]++; end
                    end
                end
            end
        end
    endfunction

    // Decision-unit stub: answers at least one cycle after the request.
    initial begin : dec_stub
        lvec lit;
        bus.dec_ended = 1'b0; bus.dec_lit = '0;
        forever begin
            @(negedge clock);
            if (bus.dec_find && !dec_hang && !reset) begin
                lit = dec_fn(bus.dec_formula);
                repeat (1 + $urandom_range(0, 3)) @(negedge clock);
                bus.dec_lit = lit; bus.dec_ended = 1'b1;
                @(negedge clock);
                bus.dec_ended = 1'b0; bus.dec_lit = lvec'($urandom);
            end
        end
    end

    initial begin : prop_stub
        logic c;
        fvec r;
        bus.prop_done = 1'b0; bus.prop_conflict = 1'b0; bus.prop_result = '0;
        forever begin
            @(negedge clock);
            bus.prop_conflict = $urandom_range(0, 1) == 1;
            if (bus.prop_start && !prop_hang && !reset) begin
                prop_fn(bus.prop_formula, bus.prop_lit, c, r);
                repeat (1 + $urandom_range(0, 3)) @(negedge clock);
                bus.prop_done = 1'b1; bus.prop_conflict = c; bus.prop_result = r;
                @(negedge clock);
                bus.prop_done = 1'b0; bus.prop_result = fvec'({$urandom, $urandom});
            end
        end
    end

    // Single compare process for every request and result the DUT presents.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.dec_find) begin
                dec_cnt++;
                checks++;
                if (exp_q.size() == 0 || exp_q[0].kind != 1'b0) begin
                    errors++;
                    $display("FAIL dec_req: unexpected dec_find, %0d events pending", exp_q.size());
                end else chk("dec_formula", 64'(bus.dec_formula), 64'(exp_q.pop_front().f));
            end
            if (bus.prop_start) begin
                seen_pf.push_back(bus.prop_formula);
                seen_pl.push_back(bus.prop_lit);
                checks++;
                if (exp_q.size() == 0 || exp_q[0].kind != 1'b1) begin
                    errors++;
                    $display("FAIL prop_req: unexpected prop_start lit %0h", bus.prop_lit);
                end else begin
                    chk("prop_formula", 64'(bus.prop_formula), 64'(exp_q[0].f));
                    chk("prop_lit", 64'(bus.prop_lit), 64'(exp_q.pop_front().l));
                end
            end
            if (active && !bus.done) chk("busy_while_running", 64'(bus.busy), 64'd1);
            if (bus.done) begin
                chk("result", 64'({bus.sat, bus.unsat, bus.err}), 64'(exp_res));
                chk("depth", 64'(bus.depth), 64'(exp_depth));
                chk("busy_at_done", 64'(bus.busy), 64'd0);
            end
        end
    end

    task automatic run(input fvec f, input int md, input bit inj, input bit dhang, output int lat);
        mode = md; dec_hang = dhang; dec_cnt = 0;
        seen_pf.delete(); seen_pl.delete();
        if (dhang) begin
            exp_q.delete(); exp_q.push_back('{1'b0, f, '0});
            exp_res = 3'b001; exp_depth = 0;
        end else model(f);
        @(negedge clock);
        bus.formula_in = f; bus.start = 1'b1;
        @(posedge clock); #1 bus.start = 1'b0;
        active = 1; lat = 1;
        forever begin
            @(negedge clock);
            if (bus.done) break;
            if (lat >= 3000) begin
                checks++; errors++;
                $display("FAIL done_timeout: no done after %0d cycles", lat);
                break;
            end
            if (inj && lat == 4) begin bus.start = 1'b1; bus.formula_in = ~f; end
            @(posedge clock); lat++;
            #1 bus.start = 1'b0;
        end
        active = 0;
        repeat (2) @(negedge clock);
        chk("no_restart", 64'(bus.busy), 64'd0);
        chk("events_left", 64'(exp_q.size()), 64'd0);
        dec_hang = 0;
    endtask

    function automatic fvec rand_formula();
        fvec f;
        for (int c = 0; c < NC; c++) f[c] = {3'($urandom_range(0, 7)), 8'($urandom)};
        return f;
    endfunction

    initial begin : main
        fvec f;
        int lat;
        bit to;
        bus.start = 1'b0; bus.formula_in = '0;
        repeat (3) @(negedge clock);
        chk("rst_outputs", 64'({bus.busy, bus.done, bus.sat, bus.unsat, bus.err, bus.dec_find, bus.prop_start}), 64'd0);
        chk("rst_depth", 64'(bus.depth), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // all clauses empty: answered without consulting the decision unit
        f = '0; for (int c = 0; c < NC; c++) f[c][PAYW-1:0] = 8'($urandom);
        run(f, M_EMPTY, 0, 0, lat);
        chk("empty_latency", 64'(lat), 64'd3);
        chk("empty_no_dec", 64'(dec_cnt), 64'd0);
        chk("empty_sat", 64'(bus.sat), 64'd1);

        f = '0; f[0] = {3'd1, 8'h13};
        run(f, M_EMPTY, 0, 0, lat);
        chk("single_lit", 64'(seen_pl[0]), 64'h07);
        chk("single_depth", 64'(bus.depth), 64'd1);

        run(f, M_CONF_ONCE, 0, 0, lat);
        chk("flip_lit", 64'(seen_pl.size() > 1 ? seen_pl[1] : 5'h1f), 64'h06);
        chk("flip_formula", 64'(seen_pf.size() > 1 ? seen_pf[1] : '0), 64'(f));
        chk("flip_sat", 64'(bus.sat), 64'd1);

        run(f, M_CONFLICT, 0, 0, lat);
        chk("unsat_flag", 64'(bus.unsat), 64'd1);
        chk("unsat_props", 64'(seen_pl.size()), 64'd2);
        chk("unsat_depth", 64'(bus.depth), 64'd0);

        // depth limit reached, with a start pulse injected while busy
        run(f, M_STUCK, 1, 0, lat);
        chk("maxd_err", 64'(bus.err), 64'd1);
        chk("maxd_decs", 64'(dec_cnt), 64'd2);

        run(f, M_EMPTY, 0, 1, lat);
        chk("wd_err", 64'(bus.err), 64'd1);
        chk("wd_latency", 64'(lat), 64'd12);

        for (int n = 0; n < 40; n++) begin
            seed = $urandom;
            run(rand_formula(), M_RAND, n % 7 == 3, 0, lat);
        end

        // reset while waiting on the propagation unit
        mode = M_STUCK; prop_hang = 1; model(f);
        @(negedge clock); bus.formula_in = f; bus.start = 1'b1;
        @(posedge clock); #1 bus.start = 1'b0;
        to = 1;
        for (int i = 0; i < 50 && to; i++) begin @(negedge clock); if (bus.prop_start) to = 0; end
        if (to) begin checks++; errors++; $display("FAIL prop_wait_timeout: no prop_start"); end
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_outputs", 64'({bus.busy, bus.done, bus.sat, bus.unsat, bus.err, bus.dec_find, bus.prop_start}), 64'd0);
        chk("mid_rst_depth", 64'(bus.depth), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0; prop_hang = 0; exp_q.delete();
        repeat (6) @(negedge clock);
        chk("post_rst_idle", 64'(bus.busy), 64'd0);

        f = '0; f[2] = {3'd2, 8'h55};
        run(f, M_CONF_ONCE, 0, 0, lat);
        chk("post_rst_sat", 64'(bus.sat), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : global_timeout
        #800000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dpll_sequencer.md
Name: dpll_sequencer

Overview:
- Top-level DPLL control FSM. Sequences the branch-decision unit (find/ended/lit handshake) and the unit-propagation unit (start/done/conflict handshake).
- Holds the decision stack of formula snapshots and literals, and performs chronological backtracking with polarity flip.
- Reports SAT/UNSAT/error to the host that loads the formula.

Parameters:
- MAX_DEPTH, 16, decision-stack entries (maximum simultaneous decisions).
- WAIT_LIMIT, 4096, maximum cycles allowed in any wait-for-subunit state before error.
- NUM_CLAUSES, 2**width_clausearray, clauses scanned by the emptiness check.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns block to IDLE.
- start  in  1  one-cycle request to solve formula_in; honoured only in IDLE.
- formula_in  in  formula  formula to solve; sampled on accepted start.
- busy  out  1  high from accepted start until the done pulse.
- done  out  1  one-cycle pulse when a result is ready.
- sat  out  1  result: satisfiable; held until next accepted start.
- unsat  out  1  result: unsatisfiable; held until next accepted start.
- err  out  1  stack overflow or watchdog expiry; held until next accepted start.
- depth  out  $clog2(MAX_DEPTH+1)  current stack depth.
- dec_find  out  1  one-cycle request to the decision unit.
- dec_formula  out  formula  current formula presented to the decision unit.
- dec_ended  in  1  decision complete, lit valid.
- dec_lit  in  lit  chosen literal (num, val).
- prop_start  out  1  one-cycle request to the propagation unit.
- prop_formula  out  formula  formula to simplify.
- prop_lit  out  lit  literal to assign.
- prop_done  in  1  propagation complete.
- prop_conflict  in  1  qualifies prop_done: empty clause produced.
- prop_result  in  formula  simplified formula; valid with prop_done when no conflict.

Behaviour:
- Reset: all outputs 0; depth 0; state IDLE; cur_formula/cur_lit cleared to zero_formula/zero_lit; stack valid bits cleared. Reset mid-operation aborts immediately; dec_find and prop_start go low asynchronously.
- Stack entry fields: snapshot formula (pre-decision), lit, flipped bit.
- Emptiness: formula is empty when every clause has len == 0. Evaluated combinationally on cur_formula.
- IDLE: on start, latch formula_in into cur_formula; clear sat/unsat/err; depth <= 0; busy <= 1 -> CHECK. start while busy is ignored.
- CHECK (1 cycle):
  - empty -> FINISH with sat = 1.
  - else, if depth == MAX_DEPTH -> FINISH with err = 1.
  - else -> DEC_REQ.
  - The decision unit is never requested on an empty formula.
- DEC_REQ: dec_find = 1 for exactly one cycle; dec_formula = cur_formula, stable until dec_ended -> DEC_WAIT.
- DEC_WAIT: on dec_ended, push {cur_formula, dec_lit, flipped = 0} at stack[depth]; depth++; cur_lit <= dec_lit -> PROP_REQ.
- PROP_REQ: prop_start = 1 for one cycle; prop_formula/prop_lit held stable until prop_done -> PROP_WAIT.
- PROP_WAIT: on prop_done:
  - prop_conflict = 1 -> BACKTRACK.
  - else cur_formula <= prop_result -> CHECK.
- BACKTRACK (one stack action per cycle):
  - depth == 0 -> FINISH with unsat = 1.
  - top (stack[depth-1]) flipped == 0: set flipped = 1; cur_lit <= {top.num, ~top.val}; cur_formula <= top snapshot -> PROP_REQ.
  - top flipped == 1: depth-- and stay in BACKTRACK.
- FINISH: done = 1 for one cycle; busy <= 0 -> IDLE. Exactly one of sat/unsat/err is set.
- Watchdog: counter cleared on entry to DEC_WAIT/PROP_WAIT and incremented each cycle there. When it reaches WAIT_LIMIT -> FINISH with err = 1.
- Stray handshakes: dec_ended outside DEC_WAIT and prop_done outside PROP_WAIT are ignored. prop_conflict is don't-care without prop_done.
- Latencies:
  - start-to-done on an empty formula: 3 cycles.
  - Each decision adds 2 + decide latency.
  - Each propagation adds 2 + propagation latency.
  - Each pop adds 1.

Test Plan:
- All clauses len 0, start -> no dec_find; done at cycle 3 with sat = 1, unsat = 0, depth 0.
- Single clause {x3 = 1}: stub decides {3,1}; prop returns empty formula -> prop_lit = {3,1}; sat = 1, depth 1.
- Stub prop conflicts on {3,1}, then succeeds to empty -> second prop_lit = {3,0} with the original snapshot on prop_formula; sat = 1.
- Stub prop always conflicts -> prop_lit {3,1} then {3,0}, then pop; unsat = 1, depth 0.
- MAX_DEPTH = 2, prop never empties or conflicts -> two pushes, then err = 1 with no third dec_find.
- Edge cases:
  - Decision stub never asserts dec_ended, WAIT_LIMIT = 8 -> err = 1 after 8 wait cycles.
  - start pulsed while busy -> ignored.
  - reset during PROP_WAIT -> busy = 0, depth = 0, outputs 0 next cycle.
